// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_fetch_pkg : shared types and constants for the fetch front end      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package riscv_fetch_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // pc is sized for the widest supported XLEN; narrower builds use the low bits
  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             insn;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_prefetch_unit_if : imem request/response and IF/ID delivery bundle  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface fetch_prefetch_unit_if #(
  parameter int XLEN = riscv_fetch_pkg::DEFAULT_XLEN
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instruction;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  if_ready,
    output if_valid, if_pc, if_instruction
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output if_ready,
    input  if_valid, if_pc, if_instruction
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue : synchronous FIFO of {pc, insn} entries, flush beats push    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_pop;
  logic           do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_prefetch_unit : grant/valid instruction fetch with prefetch queue   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_prefetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc,
  fetch_prefetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   q_count_nxt;
  logic            fetch_req;
  logic            req_nxt;
  logic            gnt_fire;
  logic            rv_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign gnt_fire  = fetch_req && bus.imem_gnt;
  // a response with nothing in flight is a protocol error and is ignored
  assign rv_fire   = bus.imem_rvalid && (outstanding != '0);
  assign push      = rv_fire && (drop_cnt == '0);
  assign pop       = bus.if_valid && bus.if_ready;
  assign push_data = '{pc: DEFAULT_XLEN'(resp_pc), insn: bus.imem_rdata};

  assign out_nxt     = outstanding + CW'(gnt_fire) - CW'(rv_fire);
  assign q_count_nxt = redirect ? '0 : (q_count + CW'(push) - CW'(pop));

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (rv_fire && (drop_cnt != '0)) drop_nxt = drop_cnt - CW'(1);
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_DRAIN: if (drop_nxt == '0) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
    // every response still in flight after this edge belongs to the old path
    if (redirect) begin
      drop_nxt  = out_nxt;
      state_nxt = (out_nxt != '0) ? S_DRAIN : S_RUN;
    end
  end

  // throttle on the post-edge totals so a granted fetch always has a slot
  assign req_nxt = (state_nxt == S_RUN) && !redirect &&
                   (({1'b0, q_count_nxt} + {1'b0, out_nxt}) < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_req   <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      fetch_req   <= req_nxt;
      if (redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)     resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (q_count)
  );

  assign bus.imem_req       = fetch_req;
  assign bus.imem_addr      = fetch_pc;
  assign bus.if_valid       = (q_count != '0);
  assign bus.if_pc          = bus.if_valid ? head.pc[XLEN-1:0] : resp_pc;
  assign bus.if_instruction = bus.if_valid ? head.insn : NOP_INSN;

endmodule
`default_nettype wire
